// File: rtl/countdown_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer_if
// Description : Control/status bundle between a timer client and the
//               loadable countdown timer.
// Revision    : 1.0 - initial release
// ============================================================================
interface countdown_timer_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
    logic             periodic;
    logic             tick_en;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
    logic             done;

    modport master (
        output load, load_val, start, stop, periodic, tick_en,
        input  count, tc, busy, done
    );

    modport slave (
        input  load, load_val, start, stop, periodic, tick_en,
        output count, tc, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer
// Description : Loadable down-counter with one-shot / periodic modes and a
//               registered one-cycle terminal-count pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer #(
    parameter int WIDTH = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    countdown_timer_if.slave  bus
);

    localparam logic [WIDTH-1:0] c_ZERO = '0;
    localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_tc;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_start_val;
    logic             w_start_ok;

    // A load in the same cycle as start takes effect for that start.
    assign w_start_val = bus.load ? bus.load_val : r_reload;
    assign w_start_ok  = bus.start && !bus.stop && (w_start_val != c_ZERO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_count  <= c_ZERO;
            r_reload <= c_ZERO;
            r_tc     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (bus.load) begin
                r_reload <= bus.load_val;
            end

            case (r_state)
                S_RUN: begin
                    if (bus.stop) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_start_ok) begin
                        r_count <= w_start_val;
                    end else if (bus.tick_en) begin
                        if (r_count == c_ONE) begin
                            r_tc <= 1'b1;
                            if (bus.periodic) begin
                                // Reloading a zero period ends the run.
                                r_count <= r_reload;
                                if (r_reload == c_ZERO) begin
                                    r_state <= S_IDLE;
                                    r_busy  <= 1'b0;
                                end
                            end else begin
                                r_count <= c_ZERO;
                                r_state <= S_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end else if (r_count != c_ZERO) begin
                            r_count <= r_count - c_ONE;
                        end
                    end
                end

                default: begin
                    if (w_start_ok) begin
                        r_count <= w_start_val;
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end else if (bus.load) begin
                        r_count <= bus.load_val;
                        r_done  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.count = r_count;
    assign bus.tc    = r_tc;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_countdown_timer
// Description : Directed self-checking bench for countdown_timer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;

    localparam int WIDTH = 4;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    countdown_timer_if #(.WIDTH(WIDTH)) bus ();

    countdown_timer #(.WIDTH(WIDTH)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.load     = 1'b0;
        bus.load_val = '0;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.periodic = 1'b0;
        bus.tick_en  = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_count"}, int'(bus.count), 0);
        chk({tag, "_tc"},    int'(bus.tc),    0);
        chk({tag, "_busy"},  int'(bus.busy),  0);
        chk({tag, "_done"},  int'(bus.done),  0);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        idle_inputs();

        // T1: reset state
        rst = 1'b1;
        #1;
        chk_all_zero("t1_reset");
        @(posedge clk);
        #1 rst = 1'b0;
        step();

        // T2: one-shot 5
        bus.load_val = 4'd5; bus.load = 1'b1;
        step();
        chk("t2_loaded", int'(bus.count), 5);
        chk("t2_idle_busy", int'(bus.busy), 0);
        bus.load = 1'b0; bus.start = 1'b1;
        step();
        chk("t2_start_count", int'(bus.count), 5);
        chk("t2_start_busy", int'(bus.busy), 1);
        bus.start = 1'b0; bus.tick_en = 1'b1;
        for (int i = 4; i >= 1; i--) begin
            step();
            chk("t2_count", int'(bus.count), i);
            chk("t2_tc_low", int'(bus.tc), 0);
        end
        step();
        chk("t2_exp_count", int'(bus.count), 0);
        chk("t2_exp_tc", int'(bus.tc), 1);
        chk("t2_exp_done", int'(bus.done), 1);
        chk("t2_exp_busy", int'(bus.busy), 0);
        step();
        chk("t2_tc_oneshot", int'(bus.tc), 0);
        chk("t2_done_sticky", int'(bus.done), 1);
        chk("t2_count_hold", int'(bus.count), 0);

        // T3: periodic 3, load+start same cycle
        bus.tick_en = 1'b0; bus.periodic = 1'b1;
        bus.load_val = 4'd3; bus.load = 1'b1; bus.start = 1'b1;
        step();
        chk("t3_start_count", int'(bus.count), 3);
        chk("t3_done_clr", int'(bus.done), 0);
        bus.load = 1'b0; bus.start = 1'b0; bus.tick_en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("t3_count", int'(bus.count), (k % 3 == 1) ? 2 : (k % 3 == 2) ? 1 : 3);
            chk("t3_tc", int'(bus.tc), (k % 3 == 0) ? 1 : 0);
            chk("t3_busy", int'(bus.busy), 1);
        end
        chk("t3_done", int'(bus.done), 0);
        bus.tick_en = 1'b0; bus.stop = 1'b1;
        step();
        chk("t3_stop_busy", int'(bus.busy), 0);
        chk("t3_stop_count", int'(bus.count), 3);
        bus.stop = 1'b0; bus.periodic = 1'b0;

        // T4: gated ticks, stop at 9, restart
        bus.load_val = 4'd15; bus.load = 1'b1;
        step();
        chk("t4_loaded", int'(bus.count), 15);
        bus.load = 1'b0; bus.start = 1'b1;
        step();
        chk("t4_start", int'(bus.count), 15);
        bus.start = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            bus.tick_en = 1'b1;
            step();
            chk("t4_tick", int'(bus.count), 15 - i);
            bus.tick_en = 1'b0;
            step();
            chk("t4_gap", int'(bus.count), 15 - i);
        end
        bus.stop = 1'b1;
        step();
        chk("t4_stop_busy", int'(bus.busy), 0);
        chk("t4_stop_hold", int'(bus.count), 9);
        chk("t4_stop_tc", int'(bus.tc), 0);
        bus.stop = 1'b0; bus.start = 1'b1;
        step();
        chk("t4_restart", int'(bus.count), 15);
        chk("t4_restart_busy", int'(bus.busy), 1);
        bus.start = 1'b0; bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;

        // T5a: start with reload 0 ignored
        bus.load_val = 4'd0; bus.load = 1'b1;
        step();
        bus.load = 1'b0; bus.start = 1'b1;
        step();
        chk("t5_zero_busy", int'(bus.busy), 0);
        chk("t5_zero_count", int'(bus.count), 0);
        // T5b: load 7 + start
        bus.load_val = 4'd7; bus.load = 1'b1;
        step();
        chk("t5_ls_count", int'(bus.count), 7);
        chk("t5_ls_busy", int'(bus.busy), 1);
        // T5c: load 2 during RUN
        bus.start = 1'b0; bus.load_val = 4'd2;
        bus.periodic = 1'b1; bus.tick_en = 1'b1;
        step();
        chk("t5_run_load", int'(bus.count), 6);
        bus.load = 1'b0;
        for (int i = 5; i >= 1; i--) begin
            step();
            chk("t5_run_count", int'(bus.count), i);
        end
        step();
        chk("t5_reload2", int'(bus.count), 2);
        chk("t5_reload2_tc", int'(bus.tc), 1);
        step();
        chk("t5_p2_count", int'(bus.count), 1);
        step();
        chk("t5_p2_wrap", int'(bus.count), 2);
        chk("t5_p2_tc", int'(bus.tc), 1);
        // T5d: stop + start in RUN
        bus.tick_en = 1'b0; bus.stop = 1'b1; bus.start = 1'b1;
        step();
        chk("t5_ss_busy", int'(bus.busy), 0);
        chk("t5_ss_count", int'(bus.count), 2);
        chk("t5_ss_tc", int'(bus.tc), 0);
        bus.stop = 1'b0; bus.start = 1'b0;

        // T6: async reset during periodic RUN at count 2
        bus.load_val = 4'd3; bus.load = 1'b1; bus.start = 1'b1;
        step();
        bus.load = 1'b0; bus.start = 1'b0; bus.tick_en = 1'b1;
        step();
        chk("t6_pre_count", int'(bus.count), 2);
        chk("t6_pre_busy", int'(bus.busy), 1);
        #1 rst = 1'b1;
        #1;
        chk_all_zero("t6_async");
        idle_inputs();
        @(posedge clk);
        #1 rst = 1'b0;
        bus.start = 1'b1;
        step();
        chk("t6_start_ign_busy", int'(bus.busy), 0);
        chk("t6_start_ign_count", int'(bus.count), 0);
        bus.start = 1'b0; bus.load_val = 4'd4; bus.load = 1'b1;
        step();
        chk("t6_load_count", int'(bus.count), 4);
        bus.load = 1'b0; bus.start = 1'b1;
        step();
        chk("t6_start_busy", int'(bus.busy), 1);
        chk("t6_start_count", int'(bus.count), 4);
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
